// File: rtl/shift_arbiter.sv
// Two-port arbiter that time-shares one combinational 16-bit shifter.
// Grants one request at a time, lets the shifter settle, then returns a tagged response.
module shift_arbiter #(
   parameter int unsigned WAIT_CYCLES = 1,
   parameter int unsigned CNT_W       = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [1:0]  req_op0,
   input  logic [1:0]  req_op1,
   input  logic [15:0] req_a0,
   input  logic [15:0] req_a1,
   input  logic [15:0] req_b0,
   input  logic [15:0] req_b1,
   output logic [1:0]  sh_op,
   output logic [15:0] sh_a,
   output logic [15:0] sh_b,
   input  logic [15:0] sh_y,
   input  logic        sh_ovf,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [15:0] rsp_y,
   output logic        rsp_ovf,
   output logic        busy
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e             state_q, state_d;
   logic               prio_q, prio_d;
   logic               id_q, id_d;
   logic [1:0]         op_q, op_d;
   logic [15:0]        a_q, a_d;
   logic [3:0]         amt_q, amt_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               rsp_id_q, rsp_id_d;
   logic [15:0]        rsp_y_q, rsp_y_d;
   logic               rsp_ovf_q, rsp_ovf_d;
   logic               grant;

   // Only the low nibble of B is a shift amount.
   logic unused_b;
   assign unused_b = ^{req_b0[15:4], req_b1[15:4]};

   always_comb begin
      state_d   = state_q;
      prio_d    = prio_q;
      id_d      = id_q;
      op_d      = op_q;
      a_d       = a_q;
      amt_d     = amt_q;
      cnt_d     = cnt_q;
      rsp_id_d  = rsp_id_q;
      rsp_y_d   = rsp_y_q;
      rsp_ovf_d = rsp_ovf_q;
      req_ready = 2'b00;
      grant     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_valid != 2'b00) begin
               // Contention goes to the pointer; a lone requester always wins.
               grant     = (req_valid == 2'b11) ? prio_q : req_valid[1];
               req_ready = grant ? 2'b10 : 2'b01;
               id_d      = grant;
               op_d      = grant ? req_op1 : req_op0;
               a_d       = grant ? req_a1 : req_a0;
               amt_d     = grant ? req_b1[3:0] : req_b0[3:0];
               cnt_d     = CNT_W'(WAIT_CYCLES - 1);
               state_d   = StExec;
            end
         end
         StExec: begin
            if (cnt_q == '0) begin
               rsp_y_d   = sh_y;
               rsp_ovf_d = sh_ovf & (op_q == 2'b11);
               rsp_id_d  = id_q;
               state_d   = StResp;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               prio_d  = ~rsp_id_q;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         prio_q    <= 1'b0;
         id_q      <= 1'b0;
         op_q      <= 2'b00;
         a_q       <= 16'h0000;
         amt_q     <= 4'h0;
         cnt_q     <= '0;
         rsp_id_q  <= 1'b0;
         rsp_y_q   <= 16'h0000;
         rsp_ovf_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         prio_q    <= prio_d;
         id_q      <= id_d;
         op_q      <= op_d;
         a_q       <= a_d;
         amt_q     <= amt_d;
         cnt_q     <= cnt_d;
         rsp_id_q  <= rsp_id_d;
         rsp_y_q   <= rsp_y_d;
         rsp_ovf_q <= rsp_ovf_d;
      end
   end

   // Shifter inputs come straight from the capture registers, so they hold outside EXEC.
   assign sh_op     = op_q;
   assign sh_a      = a_q;
   assign sh_b      = {12'h000, amt_q};
   assign rsp_valid = (state_q == StResp);
   assign rsp_id    = rsp_id_q;
   assign rsp_y     = rsp_y_q;
   assign rsp_ovf   = rsp_ovf_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: a WAIT_CYCLES=1 instance and a WAIT_CYCLES=3 instance,
// each driving a behavioural shifter.
module tb_shift_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // WAIT_CYCLES = 1 instance
   logic        rst1, rsp_ready1, rsp_valid1, rsp_id1, rsp_ovf1, busy1, sh_ovf1, force_ovf1;
   logic [1:0]  req_valid1, req_ready1, op0_1, op1_1, sh_op1;
   logic [15:0] a0_1, a1_1, b0_1, b1_1, sh_a1, sh_b1, sh_y1, rsp_y1;
   logic [16:0] shr1;

   // WAIT_CYCLES = 3 instance
   logic        rst3, rsp_ready3, rsp_valid3, rsp_id3, rsp_ovf3, busy3, sh_ovf3;
   logic [1:0]  req_valid3, req_ready3, op0_3, op1_3, sh_op3;
   logic [15:0] a0_3, a1_3, b0_3, b1_3, sh_a3, sh_b3, sh_y3, rsp_y3;
   logic [16:0] shr3;

   logic [17:0] q1[$];
   logic [17:0] q3[$];
   logic [17:0] e1, e3;

   function automatic logic [16:0] shf(input logic [1:0] op, input logic [15:0] a,
                                       input logic [15:0] b);
      logic [15:0] y;
      logic [3:0]  n;
      n = b[3:0];
      case (op)
         2'b00:   y = a << n;
         2'b01:   y = a >> n;
         2'b10:   y = 16'($signed(a) >>> n);
         default: y = a << n;
      endcase
      return {(op == 2'b11) ? (y[15] ^ a[15]) : 1'b0, y};
   endfunction

   assign shr1    = shf(sh_op1, sh_a1, sh_b1);
   assign sh_y1   = shr1[15:0];
   assign sh_ovf1 = shr1[16] | force_ovf1;
   assign shr3    = shf(sh_op3, sh_a3, sh_b3);
   assign sh_y3   = shr3[15:0];
   assign sh_ovf3 = shr3[16];

   shift_arbiter #(.WAIT_CYCLES(1), .CNT_W(4)) u_dut1 (
      .clk(clk), .rst(rst1), .req_valid(req_valid1), .req_ready(req_ready1),
      .req_op0(op0_1), .req_op1(op1_1), .req_a0(a0_1), .req_a1(a1_1),
      .req_b0(b0_1), .req_b1(b1_1), .sh_op(sh_op1), .sh_a(sh_a1), .sh_b(sh_b1),
      .sh_y(sh_y1), .sh_ovf(sh_ovf1), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
      .rsp_id(rsp_id1), .rsp_y(rsp_y1), .rsp_ovf(rsp_ovf1), .busy(busy1)
   );

   shift_arbiter #(.WAIT_CYCLES(3), .CNT_W(4)) u_dut3 (
      .clk(clk), .rst(rst3), .req_valid(req_valid3), .req_ready(req_ready3),
      .req_op0(op0_3), .req_op1(op1_3), .req_a0(a0_3), .req_a1(a1_3),
      .req_b0(b0_3), .req_b1(b1_3), .sh_op(sh_op3), .sh_a(sh_a3), .sh_b(sh_b3),
      .sh_y(sh_y3), .sh_ovf(sh_ovf3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
      .rsp_id(rsp_id3), .rsp_y(rsp_y3), .rsp_ovf(rsp_ovf3), .busy(busy3)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Returns at the negedge of the accept cycle; n = idle negedges skipped before it.
   task automatic wait_grant1(input logic [1:0] exp, output int n);
      n = 0;
      @(negedge clk);
      while (req_ready1 == 2'b00 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("grant1", {30'd0, req_ready1}, {30'd0, exp});
   endtask

   // Monitors: pop on every response handshake.
   always @(negedge clk) begin
      if (!rst1 && rsp_valid1 && rsp_ready1) begin
         if (q1.size() == 0) chk("rsp1_unexpected", q1.size(), 1);
         else begin
            e1 = q1.pop_front();
            chk("rsp1", {14'd0, rsp_id1, rsp_ovf1, rsp_y1}, {14'd0, e1});
         end
      end
   end

   always @(negedge clk) begin
      if (!rst3 && rsp_valid3 && rsp_ready3) begin
         if (q3.size() == 0) chk("rsp3_unexpected", q3.size(), 1);
         else begin
            e3 = q3.pop_front();
            chk("rsp3", {14'd0, rsp_id3, rsp_ovf3, rsp_y3}, {14'd0, e3});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      rst1 = 1'b1; rst3 = 1'b1;
      req_valid1 = 2'b00; req_valid3 = 2'b00;
      rsp_ready1 = 1'b1; rsp_ready3 = 1'b1; force_ovf1 = 1'b0;
      op0_1 = 2'b00; op1_1 = 2'b00; a0_1 = '0; a1_1 = '0; b0_1 = '0; b1_1 = '0;
      op0_3 = 2'b00; op1_3 = 2'b00; a0_3 = '0; a1_3 = '0; b0_3 = '0; b1_3 = '0;
      repeat (2) step();
      @(negedge clk);
      chk("rst_req_ready", {30'd0, req_ready1}, 0);
      chk("rst_rsp", {13'd0, rsp_valid1, rsp_id1, rsp_ovf1, rsp_y1, busy1}, 0);
      chk("rst_sh", {14'd0, sh_op1, sh_a1}, 0);
      chk("rst_sh_b", {16'd0, sh_b1}, 0);
      chk("rst3_state", {28'd0, rsp_valid3, busy3, req_ready3}, 0);
      step();
      rst1 = 1'b0; rst3 = 1'b0;

      // ALS with sign change on port 0
      op0_1 = 2'b11; a0_1 = 16'h4000; b0_1 = 16'h0001; req_valid1 = 2'b01;
      wait_grant1(2'b01, n);
      q1.push_back({1'b0, 1'b1, 16'h8000});
      step(); req_valid1 = 2'b00;
      @(negedge clk);
      chk("t1_exec_sh_b", {16'd0, sh_b1}, 32'h0001);
      chk("t1_exec_sh_a", {16'd0, sh_a1}, 32'h4000);
      chk("t1_exec_flags", {27'd0, sh_op1, busy1, rsp_valid1, req_ready1 == 2'b00}, 32'h1D);
      @(negedge clk);
      chk("t1_latency", {31'd0, rsp_valid1}, 1);
      step();
      @(negedge clk);
      chk("t1_back_idle", {30'd0, rsp_valid1, busy1}, 0);

      // SRA on port 1: upper B bits masked, overflow masked for non-ALS
      step();
      op1_1 = 2'b10; a1_1 = 16'h8000; b1_1 = 16'h0014; force_ovf1 = 1'b1; req_valid1 = 2'b10;
      wait_grant1(2'b10, n);
      q1.push_back({1'b1, 1'b0, 16'hF800});
      step(); req_valid1 = 2'b00;
      @(negedge clk);
      chk("t2_sh_b", {16'd0, sh_b1}, 32'h0004);
      @(negedge clk);
      chk("t2_latency", {31'd0, rsp_valid1}, 1);
      step(); force_ovf1 = 1'b0;

      // Contention from reset: alternating grants, 3 cycles apart
      rst1 = 1'b1; step(); rst1 = 1'b0;
      op0_1 = 2'b00; a0_1 = 16'h0001; b0_1 = 16'h0002;
      op1_1 = 2'b01; a1_1 = 16'h8000; b1_1 = 16'h0003;
      req_valid1 = 2'b11;
      for (int k = 0; k < 4; k++) begin
         wait_grant1((k % 2 == 1) ? 2'b10 : 2'b01, n);
         if (k > 0) chk("t3_interval", n + 1, 3);
         if (k % 2 == 1) q1.push_back({1'b1, 1'b0, 16'h1000});
         else            q1.push_back({1'b0, 1'b0, 16'h0004});
      end
      step(); req_valid1 = 2'b00;
      repeat (3) step();

      // Back-pressure in RESP
      rsp_ready1 = 1'b0; req_valid1 = 2'b11;
      wait_grant1(2'b01, n);
      q1.push_back({1'b0, 1'b0, 16'h0004});
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         chk("t4_hold_rsp", {14'd0, rsp_valid1, rsp_id1, rsp_y1}, 32'h20004);
         chk("t4_no_ready", {30'd0, req_ready1}, 0);
         if (i < 3) @(negedge clk);
      end
      step(); rsp_ready1 = 1'b1;
      @(negedge clk);
      chk("t4_no_ready_hs", {30'd0, req_ready1}, 0);
      step();
      @(negedge clk);
      chk("t4_next_grant", {30'd0, req_ready1}, 2);
      q1.push_back({1'b1, 1'b0, 16'h1000});
      step(); req_valid1 = 2'b00;
      repeat (3) step();

      // Serve port 0 so the pointer moves to 1, then reset mid-EXEC
      req_valid1 = 2'b01;
      wait_grant1(2'b01, n);
      q1.push_back({1'b0, 1'b0, 16'h0004});
      step(); req_valid1 = 2'b00;
      repeat (2) step();
      req_valid1 = 2'b01;
      wait_grant1(2'b01, n);
      q1.push_back({1'b0, 1'b0, 16'h0004});
      step(); req_valid1 = 2'b00; rst1 = 1'b1;
      @(negedge clk);
      chk("t5_in_exec", {31'd0, busy1}, 1);
      step(); rst1 = 1'b0;
      if (q1.size() > 0) void'(q1.pop_back());
      req_valid1 = 2'b11;
      @(negedge clk);
      chk("t5_after_rst", {14'd0, busy1, rsp_valid1, rsp_y1}, 0);
      chk("t5_prio_reset", {30'd0, req_ready1}, 1);
      #1 req_valid1 = 2'b10;
      #1 chk("t5_port1_now", {30'd0, req_ready1}, 2);
      q1.push_back({1'b1, 1'b0, 16'h1000});
      step(); req_valid1 = 2'b00;
      @(negedge clk);
      @(negedge clk);
      chk("t5_rsp", {31'd0, rsp_valid1}, 1);
      step();

      // WAIT_CYCLES = 3
      op0_3 = 2'b00; a0_3 = 16'h00FF; b0_3 = 16'h0004; req_valid3 = 2'b01;
      n = 0;
      @(negedge clk);
      while (req_ready3 == 2'b00 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("t6_grant", {30'd0, req_ready3}, 1);
      q3.push_back({1'b0, 1'b0, 16'h0FF0});
      step(); req_valid3 = 2'b00;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t6_sh_stable", {sh_a3, sh_b3}, 32'h00FF_0004);
         chk("t6_exec", {30'd0, busy3, rsp_valid3}, 2);
      end
      @(negedge clk);
      chk("t6_latency", {31'd0, rsp_valid3}, 1);
      repeat (3) step();

      chk("q1_drained", q1.size(), 0);
      chk("q3_drained", q3.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
